tx_interface: RTL
=================

# tx_interface

Transmit-side counterpart of the UART receive interface. Result bytes from the ALU datapath are buffered in a small FIFO. Each byte is then handed one at a time to the UART transmitter over a start/done handshake. The block sits between the ALU result register and the UART TX core, and is the mirror of the RX FIFO → operand-collection path.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each byte/word.
- FIFO_DEPTH, 4, number of FIFO entries; must be a power of two ≥ 2.

Ports:
- i_clock  in  1  single system clock; all logic on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_data  in  DATA_WIDTH  byte to enqueue.
- i_valid  in  1  enqueue strobe; one byte written per cycle sampled high.
- o_full  out  1  FIFO holds FIFO_DEPTH entries.
- o_empty  out  1  FIFO holds 0 entries.
- o_overflow  out  1  sticky: a push was attempted while full.
- o_tx_data  out  DATA_WIDTH  byte presented to the UART TX; held stable until the next start.
- o_tx_start  out  1  one-cycle pulse requesting transmission of o_tx_data.
- i_tx_done  in  1  pulse from UART TX: current frame (including stop bit) finished.
- o_busy  out  1  high while a handed-off byte is not yet confirmed done.

## Operation
- The FIFO is a circular buffer with rd_ptr, wr_ptr and count, where count has width log2(FIFO_DEPTH)+1.
  - o_full = (count == FIFO_DEPTH).
  - o_empty = (count == 0).
  - Pointers wrap modulo FIFO_DEPTH.
- Push: when i_valid=1 and (not full, or a pop occurs the same cycle):
  - mem[wr_ptr] <= i_data;
  - wr_ptr increments.
- Push while full with no pop in the same cycle:
  - the byte is dropped;
  - contents and pointers are unchanged;
  - o_overflow <= 1, and stays 1 until reset.
- Simultaneous push and pop: both are performed and count is unchanged.
- FSM states and transitions:
  - IDLE: if !o_empty, then pop:
    - o_tx_data <= mem[rd_ptr];
    - rd_ptr increments;
    - o_tx_start <= 1;
    - go to START.
    - Otherwise stay in IDLE.
  - START: o_tx_start <= 0; go to BUSY.
  - BUSY: if i_tx_done=1, go to IDLE; otherwise stay in BUSY.
- i_tx_done is ignored in IDLE and START.
- o_busy = (state != IDLE).
- Reset values:
  - o_tx_start=0, o_tx_data=0, o_overflow=0, o_busy=0;
  - o_full=0, o_empty=1;
  - pointers and count = 0;
  - state = IDLE.
- Reset mid-operation:
  - any queued bytes are discarded;
  - an in-flight frame is abandoned;
  - no o_tx_start is issued until a new push.

## Timing
- Every output is a register or a decode of registers; there is no combinational path from an input to an output.
- Push at edge E0 → o_empty falls after E0.
- FSM pops at E1 → o_tx_start is high and o_tx_data is valid for exactly the cycle E1–E2.
- Latency from i_valid sampled to o_tx_start high: 1 cycle (push-to-start latency is 2 edges).
- i_tx_done sampled at edge Ed → state is IDLE after Ed.
  - If the FIFO is non-empty, the next o_tx_start rises at Ed+1.
  - Minimum spacing between consecutive starts: 3 cycles, with i_tx_done arriving the cycle after START.
- A pop frees an entry in the same edge it occurs, so a push on that edge succeeds even when the FIFO was full.

## Test plan
- Reset, then push 0x81, 0x7E, 0x08 on consecutive cycles:
  - o_tx_start pulses once with o_tx_data=0x81;
  - after i_tx_done, it pulses once each for 0x7E and then 0x08;
  - o_empty=1 and o_busy=0 at the end.
- Reset values: hold i_reset=1 and check every output's reset value. Pulse i_tx_done and i_valid=0 while idle: no o_tx_start.
- Fill the FIFO and trigger overflow:
  - hold i_tx_done=0 and push 0x01–0x05 (FIFO_DEPTH=4);
  - 0x01 goes out on start and 0x02–0x05 fill the FIFO;
  - o_full=1 and o_overflow=0;
  - push 0x06: dropped and o_overflow=1;
  - the drained sequence is 0x02, 0x03, 0x04, 0x05, with 0x06 absent.
- Full plus simultaneous pop:
  - with the FIFO full and BUSY, assert i_tx_done, then push 0xAA on the pop edge;
  - 0xAA is accepted, o_overflow stays 0, count stays 4, and 0xAA is transmitted last.
- Pointer wrap-around: push and drain 10 bytes 0x10–0x19 with random i_tx_done delays of 1–20 cycles; the output order matches the input order exactly.
- Asynchronous reset mid-operation:
  - while in BUSY with 2 bytes queued, assert i_reset between clock edges;
  - outputs immediately take their reset values;
  - after release, no o_tx_start occurs until a new push.

Source files
------------

// File: rtl/tx_interface.sv
// Transmit-side buffer: queues ALU result bytes in a small circular FIFO and
// hands them one at a time to the UART transmitter over a start/done handshake.
module tx_interface #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_overflow,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_start,
    input  logic                  i_tx_done,
    output logic                  o_busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] txData_q, txData_d;
    logic                  txStart_q, txStart_d;
    logic                  overflow_q, overflow_d;
    logic                  fifoFull, fifoEmpty;
    logic                  doPop, doPush;

    assign fifoFull  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifoEmpty = (count_q == '0);

    assign o_full     = fifoFull;
    assign o_empty    = fifoEmpty;
    assign o_overflow = overflow_q;
    assign o_tx_data  = txData_q;
    assign o_tx_start = txStart_q;
    assign o_busy     = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        txData_d   = txData_q;
        txStart_d  = 1'b0;
        doPop      = 1'b0;
        rdPtr_d    = rdPtr_q;
        wrPtr_d    = wrPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    doPop     = 1'b1;
                    txData_d  = mem_q[rdPtr_q];
                    txStart_d = 1'b1;
                    state_d   = START;
                end
            end
            START:   state_d = BUSY;
            BUSY:    if (i_tx_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A pop on this edge frees a slot, so a push to a full FIFO still lands.
        doPush = i_valid && (!fifoFull || doPop);
        if (i_valid && fifoFull && !doPop) begin
            overflow_d = 1'b1;
        end

        if (doPush) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        if (doPush && !doPop) begin
            count_d = count_q + CNT_W'(1);
        end else if (doPop && !doPush) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            count_q    <= '0;
            txData_q   <= '0;
            txStart_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            count_q    <= count_d;
            txData_q   <= txData_d;
            txStart_q  <= txStart_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge i_clock) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= i_data;
        end
    end
endmodule
